// File: rtl/resp_tx_arbiter_if.sv
// rtl/resp_tx_arbiter_if.sv - requester, transmitter and status signals of the response arbiter
interface resp_tx_arbiter_if;
    logic       req0_wr;
    logic [7:0] req0_data;
    logic       req0_full;
    logic       req1_wr;
    logic [7:0] req1_data;
    logic       req1_full;
    logic       resp_trmt;
    logic [7:0] resp_tx_data;
    logic       resp_tx_done;
    logic       busy;
    logic       ovf;
    logic       clr_ovf;

    modport slave (
        input  req0_wr, req0_data, req1_wr, req1_data, resp_tx_done, clr_ovf,
        output req0_full, req1_full, resp_trmt, resp_tx_data, busy, ovf
    );

    modport master (
        output req0_wr, req0_data, req1_wr, req1_data, resp_tx_done, clr_ovf,
        input  req0_full, req1_full, resp_trmt, resp_tx_data, busy, ovf
    );
endinterface

// File: rtl/resp_tx_arbiter.sv
// rtl/resp_tx_arbiter.sv - two-FIFO round-robin arbiter sharing one UART response transmitter
module resp_tx_arbiter #(
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    resp_tx_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_t;

    state_t        state_q, state_d;
    logic          trmt_q, trmt_d;
    logic [7:0]    data_q, data_d;
    logic          last_q, last_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wptr_q [2];
    logic [AW-1:0] wptr_d [2];
    logic [AW-1:0] rptr_q [2];
    logic [AW-1:0] rptr_d [2];
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];
    logic [7:0]    mem_q  [2][DEPTH];
    logic [7:0]    mem_d  [2][DEPTH];

    logic [1:0] wr, ne, full, do_wr, pop;
    logic [7:0] wdata [2];
    logic       grant;

    assign wr       = {bus.req1_wr, bus.req0_wr};
    assign wdata[0] = bus.req0_data;
    assign wdata[1] = bus.req1_data;
    assign ne       = {cnt_q[1] != '0, cnt_q[0] != '0};
    assign full     = {cnt_q[1] == CW'(DEPTH), cnt_q[0] == CW'(DEPTH)};
    // A write to a full FIFO is dropped even when that FIFO pops in the same cycle.
    assign do_wr    = wr & ~full;

    always_comb begin
        state_d = state_q;
        trmt_d  = 1'b0;
        data_d  = data_q;
        last_d  = last_q;
        pop     = '0;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|ne) begin
                    grant       = (&ne) ? ~last_q : ne[1];
                    pop[grant]  = 1'b1;
                    data_d      = mem_q[grant][rptr_q[grant]];
                    trmt_d      = 1'b1;
                    last_d      = grant;
                    state_d     = LOAD;
                end
            end
            // done may still be high from the previous byte, so LOAD never samples it.
            LOAD: state_d = BUSY;
            BUSY: if (bus.resp_tx_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ovf_d = (ovf_q & ~bus.clr_ovf) | (|(wr & full));

        mem_d = mem_q;
        for (int i = 0; i < 2; i++) begin
            wptr_d[i] = wptr_q[i] + AW'(do_wr[i]);
            rptr_d[i] = rptr_q[i] + AW'(pop[i]);
            cnt_d[i]  = cnt_q[i] + CW'(do_wr[i]) - CW'(pop[i]);
            if (do_wr[i]) mem_d[i][wptr_q[i]] = wdata[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            trmt_q  <= 1'b0;
            data_q  <= 8'h00;
            last_q  <= 1'b1;
            ovf_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            trmt_q  <= trmt_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < 2; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.req0_full    = full[0];
    assign bus.req1_full    = full[1];
    assign bus.resp_trmt    = trmt_q;
    assign bus.resp_tx_data = data_q;
    assign bus.busy         = (state_q != IDLE) | (|ne);
    assign bus.ovf          = ovf_q;
endmodule

// File: tb/tb_resp_tx_arbiter.sv
// tb/tb_resp_tx_arbiter.sv - scoreboard bench for resp_tx_arbiter
module tb_resp_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   trmt_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    resp_tx_arbiter_if bif();

    resp_tx_arbiter #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bif.resp_trmt) begin
            obs_q.push_back(bif.resp_tx_data);
            trmt_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic w0, input logic [7:0] d0, input logic w1, input logic [7:0] d1);
        bif.req0_wr = w0; bif.req0_data = d0;
        bif.req1_wr = w1; bif.req1_data = d1;
        tick();
        bif.req0_wr = 1'b0;
        bif.req1_wr = 1'b0;
    endtask

    // Transmitter model: wait for a start pulse, drop done after LOAD, raise it lat cycles later.
    task automatic serve(input int lat);
        int c0 = trmt_cnt;
        int n = 0;
        while (trmt_cnt == c0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (trmt_cnt == c0) begin
            failures++;
            $display("FAIL serve_timeout: trmt_cnt=%0d required>%0d", trmt_cnt, c0);
        end
        bif.resp_tx_done = 1'b0;
        repeat (lat) tick();
        bif.resp_tx_done = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks += 6;
        if (bif.resp_trmt !== 1'b0)    begin failures++; $display("FAIL rst_trmt: got %b want 0", bif.resp_trmt); end
        if (bif.resp_tx_data !== 8'h00) begin failures++; $display("FAIL rst_data: got %h want 00", bif.resp_tx_data); end
        if (bif.busy !== 1'b0)         begin failures++; $display("FAIL rst_busy: got %b want 0", bif.busy); end
        if (bif.ovf !== 1'b0)          begin failures++; $display("FAIL rst_ovf: got %b want 0", bif.ovf); end
        if (bif.req0_full !== 1'b0)    begin failures++; $display("FAIL rst_full0: got %b want 0", bif.req0_full); end
        if (bif.req1_full !== 1'b0)    begin failures++; $display("FAIL rst_full1: got %b want 0", bif.req1_full); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] e, o;
        exp_q.push_back(8'h01); exp_q.push_back(8'h81);
        exp_q.push_back(8'h02); exp_q.push_back(8'h82);
        wr(1'b1, 8'h01, 1'b1, 8'h81);
        wr(1'b1, 8'h02, 1'b1, 8'h82);
        repeat (4) serve(3);
        repeat (3) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL rr_order: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL rr_order: got %h want %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL rr_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_single();
        logic [7:0] e, o;
        int c0 = trmt_cnt;
        exp_q.push_back(8'hA5);
        wr(1'b1, 8'hA5, 1'b0, 8'h00);
        serve(10);
        checks += 3;
        if (bif.resp_tx_data !== 8'hA5) begin failures++; $display("FAIL single_hold: got %h want a5", bif.resp_tx_data); end
        if (bif.busy !== 1'b1)          begin failures++; $display("FAIL single_busy: got %b want 1", bif.busy); end
        if (bif.resp_trmt !== 1'b0)     begin failures++; $display("FAIL single_trmt_busy: got %b want 0", bif.resp_trmt); end
        tick();
        tick();
        checks += 2;
        if (bif.busy !== 1'b0)        begin failures++; $display("FAIL single_idle: got %b want 0", bif.busy); end
        if (trmt_cnt != c0 + 1)       begin failures++; $display("FAIL single_pulses: got %0d want %0d", trmt_cnt - c0, 1); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL single_data: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL single_data: got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_full_ovf();
        logic [7:0] e, o;
        bif.resp_tx_done = 1'b0;
        exp_q.push_back(8'h55);
        wr(1'b0, 8'h00, 1'b1, 8'h55);
        for (int i = 0; i < 4; i++) begin
            wr(1'b1, 8'h10 + 8'(i), 1'b0, 8'h00);
            exp_q.push_back(8'h10 + 8'(i));
        end
        checks += 2;
        if (bif.req0_full !== 1'b1) begin failures++; $display("FAIL full_at4: got %b want 1", bif.req0_full); end
        if (bif.ovf !== 1'b0)       begin failures++; $display("FAIL ovf_at4: got %b want 0", bif.ovf); end
        wr(1'b1, 8'hEE, 1'b0, 8'h00);
        checks += 3;
        if (bif.req0_full !== 1'b1) begin failures++; $display("FAIL full_at5: got %b want 1", bif.req0_full); end
        if (bif.ovf !== 1'b1)       begin failures++; $display("FAIL ovf_set: got %b want 1", bif.ovf); end
        if (bif.busy !== 1'b1)      begin failures++; $display("FAIL ovf_busy: got %b want 1", bif.busy); end
        bif.clr_ovf = 1'b1;
        tick();
        bif.clr_ovf = 1'b0;
        checks++;
        if (bif.ovf !== 1'b0) begin failures++; $display("FAIL ovf_clr: got %b want 0", bif.ovf); end
        bif.clr_ovf = 1'b1;
        wr(1'b1, 8'hEF, 1'b0, 8'h00);
        bif.clr_ovf = 1'b0;
        checks++;
        if (bif.ovf !== 1'b1) begin failures++; $display("FAIL ovf_set_wins: got %b want 1", bif.ovf); end
        bif.clr_ovf = 1'b1;
        tick();
        bif.clr_ovf = 1'b0;
        bif.resp_tx_done = 1'b1;
        repeat (4) serve(2);
        repeat (3) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL full_data: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL full_data: got %h want %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL full_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_stale_done();
        logic [7:0] e, o;
        int c0 = trmt_cnt;
        bif.resp_tx_done = 1'b1;
        exp_q.push_back(8'h3C);
        wr(1'b0, 8'h00, 1'b1, 8'h3C);
        tick();
        bif.resp_tx_done = 1'b0;
        repeat (5) tick();
        checks += 3;
        if (bif.busy !== 1'b1)    begin failures++; $display("FAIL stale_wait: got busy %b want 1", bif.busy); end
        if (trmt_cnt != c0 + 1)   begin failures++; $display("FAIL stale_pulses: got %0d want 1", trmt_cnt - c0); end
        if (bif.resp_trmt !== 1'b0) begin failures++; $display("FAIL stale_trmt: got %b want 0", bif.resp_trmt); end
        bif.resp_tx_done = 1'b1;
        repeat (3) tick();
        checks += 2;
        if (bif.busy !== 1'b0)  begin failures++; $display("FAIL stale_idle: got %b want 0", bif.busy); end
        if (trmt_cnt != c0 + 1) begin failures++; $display("FAIL stale_double: got %0d want 1", trmt_cnt - c0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL stale_data: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL stale_data: got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e, o;
        int c0;
        bif.resp_tx_done = 1'b0;
        exp_q.push_back(8'h77);
        wr(1'b1, 8'h77, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) wr(1'b1, 8'h78 + 8'(i), 1'b0, 8'h00);
        tick();
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (bif.resp_trmt !== 1'b0)     begin failures++; $display("FAIL rmid_trmt: got %b want 0", bif.resp_trmt); end
        if (bif.resp_tx_data !== 8'h00) begin failures++; $display("FAIL rmid_data: got %h want 00", bif.resp_tx_data); end
        if (bif.busy !== 1'b0)          begin failures++; $display("FAIL rmid_busy: got %b want 0", bif.busy); end
        if (bif.req0_full !== 1'b0)     begin failures++; $display("FAIL rmid_full: got %b want 0", bif.req0_full); end
        tick();
        rst_n = 1'b1;
        c0 = trmt_cnt;
        tick();
        bif.resp_tx_done = 1'b1;
        repeat (10) tick();
        checks += 2;
        if (trmt_cnt != c0)    begin failures++; $display("FAIL rmid_no_trmt: got %0d pulses want 0", trmt_cnt - c0); end
        if (bif.busy !== 1'b0) begin failures++; $display("FAIL rmid_idle: got %b want 0", bif.busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL rmid_data: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL rmid_data: got %h want %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL rmid_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_simul_wr_pop();
        logic [7:0] e, o;
        bif.resp_tx_done = 1'b0;
        exp_q.push_back(8'h20); exp_q.push_back(8'h90); exp_q.push_back(8'h91);
        wr(1'b1, 8'h20, 1'b0, 8'h00);
        tick();
        tick();
        wr(1'b0, 8'h00, 1'b1, 8'h90);
        bif.resp_tx_done = 1'b1;
        tick();
        wr(1'b0, 8'h00, 1'b1, 8'h91);
        bif.resp_tx_done = 1'b0;
        checks += 3;
        if (dut.cnt_q[1] !== 3'd1)       begin failures++; $display("FAIL wrpop_count: got %0d want 1", dut.cnt_q[1]); end
        if (bif.resp_trmt !== 1'b1)      begin failures++; $display("FAIL wrpop_trmt: got %b want 1", bif.resp_trmt); end
        if (bif.resp_tx_data !== 8'h90)  begin failures++; $display("FAIL wrpop_data: got %h want 90", bif.resp_tx_data); end
        repeat (3) tick();
        bif.resp_tx_done = 1'b1;
        serve(2);
        repeat (3) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL wrpop_order: got none want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL wrpop_order: got %h want %h", o, e); end
            end
        end
        checks++;
        if (bif.busy !== 1'b0) begin failures++; $display("FAIL wrpop_idle: got %b want 0", bif.busy); end
    endtask

    initial begin
        bif.req0_wr = 1'b0; bif.req0_data = 8'h00;
        bif.req1_wr = 1'b0; bif.req1_data = 8'h00;
        bif.resp_tx_done = 1'b1;
        bif.clr_ovf = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_full_ovf();
        test_stale_done();
        test_reset_mid();
        test_simul_wr_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
